// File: rtl/fifo_burst_reader_m.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_m
//
// Reads bursts of words from a first-word-fall-through FIFO and presents them
// on a valid/ready stream. A command carries a burst length. The block pops
// that many words and passes them through a 2-entry output buffer. The final
// word of each burst is tagged with m_last.
//
// Ports
//   clk, rst_n    : single clock (FIFO read side), async active-low reset
//   head, empty   : FWFT FIFO head word and empty flag
//   rd_rst_busy   : FIFO read side in reset; never pop while set
//   pop           : FIFO read enable; consumes head in the same cycle
//   cmd_len       : burst length, in words
//   cmd_valid     : burst command offered
//   cmd_ready     : command taken on cmd_valid & cmd_ready
//   m_data        : stream data
//   m_valid       : stream word present
//   m_last        : final word of a burst
//   m_ready       : sink accepts on m_valid & m_ready
//   words_left    : words of the current burst not yet popped
//   busy          : burst active or output buffer non-empty
// -----------------------------------------------------------------------------
module fifo_burst_reader_m #(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  LEN_W          = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [$bits(DATA_ITEM_TYPE)-1:0]  head,
  input  logic                              empty,
  input  logic                              rd_rst_busy,
  output logic                              pop,
  input  logic [LEN_W-1:0]                  cmd_len,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  output logic [$bits(DATA_ITEM_TYPE)-1:0]  m_data,
  output logic                              m_valid,
  output logic                              m_last,
  input  logic                              m_ready,
  output logic [LEN_W-1:0]                  words_left,
  output logic                              busy
);

  localparam int DW = $bits(DATA_ITEM_TYPE);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_words_left;
  logic [LEN_W-1:0] w_words_nxt;

  // Output buffer. Slot 0 always holds the oldest entry.
  logic [DW-1:0]    r_buf_data [2];
  logic             r_buf_last [2];
  logic [1:0]       r_count;

  logic             w_pop;
  logic             w_cmd_ready;
  logic             w_drain;
  logic             w_last_in;

  // Next-state and handshake logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    w_state_nxt = r_state;
    w_words_nxt = r_words_left;
    w_pop       = 1'b0;
    w_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated with rst_n so cmd_ready drops the moment reset is applied.
        w_cmd_ready = rst_n;
        // A zero-length command is taken but starts nothing.
        if (cmd_valid && rst_n && (cmd_len != '0)) begin
          w_state_nxt = S_BURST;
          w_words_nxt = cmd_len;
        end
      end
      S_BURST: begin
        // Never pop into a full buffer, even if a slot frees this cycle.
        // This keeps pop off the m_ready path.
        w_pop = (r_words_left != '0) && !empty && !rd_rst_busy &&
                (r_count != 2'd2);
        if (w_pop) begin
          w_words_nxt = r_words_left - LEN_W'(1);
          if (r_words_left == LEN_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_last_in = (r_words_left == LEN_W'(1));
  assign w_drain   = (r_count != 2'd0) && m_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_words_left <= w_words_nxt;
    end
  end

  // Output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both buffer slots are reset, not only the count, so m_data reads 0 in and out of reset.
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      case ({w_pop, w_drain})
        2'b10: begin
          // A push only happens with count 0 or 1, so count[0] selects the free slot.
          r_buf_data[r_count[0]] <= head;
          r_buf_last[r_count[0]] <= w_last_in;
          r_count                <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_last[0] <= r_buf_last[1];
          r_count       <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is exactly 1 here: the oldest leaves and the new word takes its slot.
          r_buf_data[0] <= head;
          r_buf_last[0] <= w_last_in;
        end
        default: ;
      endcase
    end
  end

  assign pop        = w_pop;
  assign cmd_ready  = w_cmd_ready;
  assign m_valid    = (r_count != 2'd0);
  assign m_data     = r_buf_data[0];
  assign m_last     = m_valid & r_buf_last[0];
  assign words_left = r_words_left;
  assign busy       = (r_state == S_BURST) | (r_count != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader_m.sv
`timescale 1ns/1ps
module tb_fifo_burst_reader_m;

  typedef logic [7:0] item_t;
  typedef struct packed { item_t d; logic l; } ent_t;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  item_t         head;
  logic          empty;
  logic          rd_rst_busy;
  logic          pop;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  item_t         m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [LW-1:0] words_left;
  logic          busy;

  fifo_burst_reader_m #(.DATA_ITEM_TYPE(item_t), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .head(head), .empty(empty),
    .rd_rst_busy(rd_rst_busy), .pop(pop), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .words_left(words_left), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: the source FIFO contents, the words popped but not
  // yet delivered, the words of the active burst not yet popped, and a log
  // of every delivered word.
  item_t fifo_q[$];
  ent_t  outq[$];
  ent_t  log_q[$];
  int    log_cyc[$];
  int    rem = 0;
  int    cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    empty = (fifo_q.size() == 0);
    head  = empty ? 8'hEE : fifo_q[0];
  endtask

  task automatic push_word(input item_t w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    log_q.delete();
    log_cyc.delete();
    refresh();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare every cycle at the falling edge, then apply the model's
  // transitions just after the rising edge.
  always begin : cmp_proc
    logic e_valid, e_pop, p_pop, p_shs, p_cmd;
    int   p_len;
    @(negedge clk);
    p_pop = 1'b0; p_shs = 1'b0; p_cmd = 1'b0; p_len = 0;
    if (rst_n) begin
      e_valid = (outq.size() != 0);
      e_pop   = (rem != 0) && !empty && !rd_rst_busy && (outq.size() < 2);
      check("cmd_ready", cmd_ready, rem == 0);
      check("words_left", words_left, rem);
      check("pop", pop, e_pop);
      check("m_valid", m_valid, e_valid);
      check("busy", busy, (rem != 0) || e_valid);
      if (e_valid) begin
        check("m_data", m_data, outq[0].d);
        check("m_last", m_last, outq[0].l);
      end
      p_pop = e_pop;
      p_shs = e_valid && m_ready;
      p_cmd = cmd_valid && (rem == 0);
      p_len = int'(cmd_len);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (p_shs) begin
      log_q.push_back(outq[0]);
      log_cyc.push_back(cyc);
      void'(outq.pop_front());
    end
    if (p_pop) begin
      outq.push_back('{d: fifo_q[0], l: (rem == 1)});
      void'(fifo_q.pop_front());
      rem--;
      refresh();
    end
    if (p_cmd) rem = p_len;
  end

  task automatic send_cmd(input int len);
    int k;
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 100);
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((rem != 0 || outq.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: drain timeout, words_left %0d, buffered %0d, required 0/0", name, rem, outq.size());
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [4:0] lasts;
    cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b0; rd_rst_busy = 1'b0;
    refresh();

    // Reset state.
    #1;
    check("rst_pop", pop, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_words_left", words_left, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Four words, burst of three, sink always ready.
    clear_fifo();
    push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    m_ready = 1'b1;
    send_cmd(3);
    wait_drain("t036");
    tick(2);
    check("t036_count", log_q.size(), 3);
    check("t036_w0", log_q[0].d, 8'hA0);
    check("t036_w1", log_q[1].d, 8'hA1);
    check("t036_w2", log_q[2].d, 8'hA2);
    check("t036_last", {log_q[0].l, log_q[1].l, log_q[2].l}, 3'b001);
    check("t036_consec", log_cyc[2] - log_cyc[0], 2);
    check("t036_idle", cmd_ready, 1);
    check("t036_left", fifo_q.size(), 1);

    // Zero-length command.
    clear_fifo();
    push_word(8'hB0);
    send_cmd(0);
    tick(3);
    check("t037_ready", cmd_ready, 1);
    check("t037_pop", pop, 0);
    check("t037_valid", m_valid, 0);
    check("t037_left", fifo_q.size(), 1);

    // Five-word burst into a stalled sink, then release.
    clear_fifo();
    for (int i = 0; i < 5; i++) push_word(item_t'(8'hC0 + i));
    m_ready = 1'b0;
    send_cmd(5);
    tick(6);
    check("t038_words_left", words_left, 3);
    check("t038_pop", pop, 0);
    check("t038_valid", m_valid, 1);
    check("t038_data", m_data, 8'hC0);
    check("t038_last", m_last, 0);
    m_ready = 1'b1;
    wait_drain("t038");
    tick(2);
    check("t038_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t038_data_i", log_q[i].d, 8'hC0 + i);
    for (int i = 0; i < 5; i++) lasts[4 - i] = log_q[i].l;
    check("t038_lasts", lasts, 5'b00001);

    // FIFO runs dry mid-burst, then refills.
    clear_fifo();
    push_word(8'hD0); push_word(8'hD1);
    send_cmd(4);
    tick(4);
    check("t039_words_left_a", words_left, 2);
    tick(10);
    check("t039_words_left_b", words_left, 2);
    check("t039_pop", pop, 0);
    push_word(8'hD2); push_word(8'hD3);
    wait_drain("t039");
    tick(2);
    check("t039_count", log_q.size(), 4);
    check("t039_w3", log_q[3].d, 8'hD3);
    check("t039_lasts", {log_q[0].l, log_q[1].l, log_q[2].l, log_q[3].l}, 4'b0001);

    // FIFO read side in reset.
    clear_fifo();
    rd_rst_busy = 1'b1;
    push_word(8'hE0); push_word(8'hE1); push_word(8'hE2);
    send_cmd(2);
    tick(5);
    check("t040_pop", pop, 0);
    check("t040_words_left", words_left, 2);
    check("t040_valid", m_valid, 0);
    rd_rst_busy = 1'b0;
    wait_drain("t040");
    tick(2);
    check("t040_count", log_q.size(), 2);
    check("t040_w0", log_q[0].d, 8'hE0);
    check("t040_w1", log_q[1].d, 8'hE1);
    check("t040_lasts", {log_q[0].l, log_q[1].l}, 2'b01);
    check("t040_left", fifo_q.size(), 1);

    // Reset mid-burst with the buffer full.
    clear_fifo();
    for (int i = 0; i < 5; i++) push_word(item_t'(8'hF0 + i));
    m_ready = 1'b0;
    send_cmd(5);
    tick(4);
    check("t041_pre_words_left", words_left, 3);
    check("t041_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    rem = 0;
    outq.delete();
    #1;
    check("t041_pop", pop, 0);
    check("t041_m_valid", m_valid, 0);
    check("t041_m_data", m_data, 0);
    check("t041_m_last", m_last, 0);
    check("t041_busy", busy, 0);
    check("t041_cmd_ready", cmd_ready, 0);
    check("t041_words_left", words_left, 0);
    tick(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1;
    check("t041_post_ready", cmd_ready, 1);
    check("t041_post_valid", m_valid, 0);
    tick(5);
    check("t041_post_pop", pop, 0);
    check("t041_fifo_kept", fifo_q.size(), 3);

    // Randomized traffic.
    clear_fifo();
    for (int i = 0; i < 800; i++) begin
      tick();
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push_word(item_t'($urandom));
      m_ready     = ($urandom_range(0, 3) != 0);
      rd_rst_busy = ($urandom_range(0, 7) == 0);
      cmd_valid   = ($urandom_range(0, 2) == 0);
      cmd_len     = LW'($urandom_range(0, 6));
    end
    cmd_valid = 1'b0; rd_rst_busy = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(item_t'($urandom));
    wait_drain("random");
    tick(3);
    check("final_idle", cmd_ready, 1);
    check("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader_m.md
FIFO_BURST_READER_M -- requirements
Module: fifo_burst_reader_m

Interface
REQ-001 Parameter DATA_ITEM_TYPE, default logic; type of one FIFO word and one stream word.
REQ-002 Parameter LEN_W, default 16; width of the burst length field.
REQ-003 clk  input  1  single clock; FIFO read-side clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 head  input  $bits(DATA_ITEM_TYPE)  FWFT FIFO head word; valid whenever empty=0.
REQ-006 empty  input  1  FIFO empty flag.
REQ-007 rd_rst_busy  input  1  FIFO read side in reset; no pop while 1.
REQ-008 pop  output  1  FIFO read enable; consumes head in the same cycle.
REQ-009 cmd_len  input  LEN_W  number of words to read for this burst.
REQ-010 cmd_valid  input  1  burst command offered.
REQ-011 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-012 m_data  output  $bits(DATA_ITEM_TYPE)  stream data.
REQ-013 m_valid  output  1  stream word present.
REQ-014 m_last  output  1  marks the final word of a burst.
REQ-015 m_ready  input  1  sink accepts when m_valid & m_ready.
REQ-016 words_left  output  LEN_W  words of the current burst not yet popped.
REQ-017 busy  output  1  burst active or output buffer non-empty.

Function
REQ-018 FSM states: IDLE and BURST; cmd_ready SHALL be 1 exactly in IDLE, with rst_n high.
REQ-019 IDLE, cmd handshake, cmd_len!=0 -> BURST next cycle, words_left loaded with cmd_len.
REQ-020 IDLE, cmd handshake, cmd_len==0 -> command consumed, stays IDLE, no words, no m_last.
REQ-021 Output buffer: 2-entry FIFO of {data, last}; count 0..2; m_valid = (count!=0); m_data/m_last from oldest entry.
REQ-022 pop = BURST & words_left!=0 & !empty & !rd_rst_busy & count<2, combinational from registered state and inputs.
REQ-023 Popped head enters buffer at the next clock edge; latency pop -> m_valid is 1 cycle when buffer empty.
REQ-024 Entry last bit = 1 iff words_left==1 at pop.
REQ-025 words_left decrements by 1 per pop; reaching 0 -> IDLE at the same edge.
REQ-026 Simultaneous pop and stream handshake: count unchanged, order preserved; with count==1 and m_ready held 1, one word per cycle sustained.
REQ-027 count==2 and stream handshake in same cycle: pop SHALL be 0 that cycle (count<2 rule), count -> 1.
REQ-028 New command may be accepted in IDLE while buffer still holds the previous burst's words; those words drain in order, unaffected.
REQ-029 empty=1 or rd_rst_busy=1 mid-burst: pop held 0, state and words_left held; resume when cleared.
REQ-030 m_data, m_last stable while m_valid & !m_ready.
REQ-031 busy = (state==BURST) | (count!=0).
REQ-032 pop SHALL never assert when empty=1 (no underflow); buffer never exceeds 2 entries.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, count 0, words_left 0, m_valid 0, m_last 0, m_data 0, busy 0, pop 0, cmd_ready 0.
REQ-034 Reset mid-burst abandons the burst and discards buffered words; no FIFO words popped after rst_n falls.
REQ-035 First command accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-036 FIFO holds 4 words A..D, cmd_len=3, m_ready=1 -> pop 3 cycles, stream A,B,C in consecutive cycles, m_last only on C, D stays in FIFO, IDLE after.
REQ-037 cmd_len=0 -> cmd_ready stays 1, no pop, m_valid stays 0.
REQ-038 cmd_len=5, m_ready=0 -> exactly 2 pops then pop=0; m_data stable; m_ready=1 -> remaining 3 delivered, total 5, order preserved.
REQ-039 cmd_len=4, FIFO empty after 2 words for 10 cycles, then refilled -> words_left=2 held, pop=0 while empty, burst completes with 4 words, m_last on 4th.
REQ-040 rd_rst_busy=1 with FIFO non-empty, cmd_len=2 -> no pop until rd_rst_busy=0, then 2 words.
REQ-041 rst_n pulsed low mid-burst (words_left=3, count=2) -> all outputs 0 immediately; after release cmd_ready=1, m_valid=0, no further pop.
